// File: rtl/tdm_demux_2ch.sv
// tdm_demux_2ch: frame-locked 2:1 bit-interleaved TDM demultiplexer with framing-error detection
module tdm_demux_2ch #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             E,
  input  logic             din,
  input  logic             sync,
  output logic [WIDTH-1:0] a_word,
  output logic [WIDTH-1:0] b_word,
  output logic             a_valid,
  output logic             b_valid,
  output logic             frame_err
);
  localparam int CW = $clog2(2 * WIDTH);
  localparam logic [CW-1:0] LAST = CW'(2 * WIDTH - 1);
  typedef enum logic {HUNT, RUN} state_t;
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh, b_sh, a_stage, b_stage;
  logic             pend;
  // Completed words are staged so the next frame's slot 0 can reuse the shift registers on the same edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= HUNT;
      cnt       <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      a_stage   <= '0;
      b_stage   <= '0;
      pend      <= 1'b0;
      a_word    <= '0;
      b_word    <= '0;
      a_valid   <= 1'b0;
      b_valid   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      a_valid   <= pend;
      b_valid   <= pend;
      frame_err <= 1'b0;
      pend      <= 1'b0;
      if (pend) begin
        a_word <= a_stage;
        b_word <= b_stage;
      end
      if (E) begin
        if (state == HUNT) begin
          if (sync) begin
            a_sh  <= {din, a_sh[WIDTH-1:1]};
            cnt   <= CW'(1);
            state <= RUN;
          end
        end else if (sync && cnt != '0) begin
          frame_err <= 1'b1;
          a_sh      <= {din, a_sh[WIDTH-1:1]};
          cnt       <= CW'(1);
        end else if (!sync && cnt == '0) begin
          frame_err <= 1'b1;
          state     <= HUNT;
        end else begin
          if (cnt[0]) b_sh <= {din, b_sh[WIDTH-1:1]};
          else a_sh <= {din, a_sh[WIDTH-1:1]};
          cnt <= cnt == LAST ? '0 : cnt + 1'b1;
          if (cnt == LAST) begin
            a_stage <= a_sh;
            b_stage <= {din, b_sh[WIDTH-1:1]};
            pend    <= 1'b1;
          end
        end
      end
    end
endmodule

// File: tb/tb_tdm_demux_2ch.sv
// tb_tdm_demux_2ch: directed self-checking bench for the 2-channel TDM demux
module tb_tdm_demux_2ch;
  logic clk = 0, rst_n = 0, E = 0, din = 0, sync = 0;
  logic [7:0] a_word, b_word;
  logic a_valid, b_valid, frame_err;
  tdm_demux_2ch #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .E(E), .din(din), .sync(sync),
    .a_word(a_word), .b_word(b_word), .a_valid(a_valid), .b_valid(b_valid),
    .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;
  int checks = 0, errors = 0, ecount = 0, ecyc = 0, skew = 0;
  int vcyc_q[$];
  logic [7:0] va_q[$], vb_q[$];
  always @(negedge clk) begin
    if (a_valid) begin
      vcyc_q.push_back(cyc);
      va_q.push_back(a_word);
      vb_q.push_back(b_word);
    end
    if (frame_err) begin
      ecount++;
      ecyc = cyc;
    end
    if (a_valid !== b_valid) skew++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_frame(input string tag, input int n, input int vc, input logic [7:0] a, input logic [7:0] b);
    chk({tag, "_count"}, vcyc_q.size(), n);
    if (vcyc_q.size() == n) begin
      chk({tag, "_cyc"}, vcyc_q[n-1], vc);
      chk({tag, "_a"}, va_q[n-1], a);
      chk({tag, "_b"}, vb_q[n-1], b);
    end
  endtask
  task automatic step(input logic e, input logic d, input logic s);
    E = e; din = d; sync = s;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) step(0, 0, 0);
  endtask
  task automatic send(input logic [7:0] a, input logic [7:0] b, input int n, input logic s0, input int stall_at);
    for (int i = 0; i < n; i++) begin
      step(1, (i % 2) ? b[i/2] : a[i/2], i == 0 ? s0 : 1'b0);
      if (i == stall_at) repeat (5) step(0, 1, 1);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_a_word"}, a_word, 0);
    chk({tag, "_b_word"}, b_word, 0);
    chk({tag, "_a_valid"}, a_valid, 0);
    chk({tag, "_b_valid"}, b_valid, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
  endtask
  int c0, e0;
  initial begin
    idle(3);
    chk_zero("reset");
    rst_n = 1;
    idle(2);
    e0 = ecount; c0 = cyc;
    send(8'hA5, 8'h3C, 16, 1, -1);
    idle(3);
    chk_frame("basic", 1, c0 + 17, 8'hA5, 8'h3C);
    chk("basic_err", ecount, e0);
    chk("basic_hold_a", a_word, 8'hA5);
    c0 = cyc;
    send(8'hA5, 8'h3C, 16, 1, 7);
    idle(3);
    chk_frame("stall", 2, c0 + 22, 8'hA5, 8'h3C);
    chk("stall_err", ecount, e0);
    send(8'hFF, 8'h00, 6, 1, -1);
    c0 = cyc;
    send(8'h11, 8'hEE, 16, 1, -1);
    idle(3);
    chk("early_err_count", ecount, e0 + 1);
    chk("early_err_cyc", ecyc, c0 + 1);
    chk_frame("early", 3, c0 + 17, 8'h11, 8'hEE);
    e0 = ecount; c0 = cyc;
    send(8'h22, 8'hDD, 16, 0, -1);
    idle(3);
    chk("miss_err_count", ecount, e0 + 1);
    chk("miss_err_cyc", ecyc, c0 + 1);
    chk("miss_no_valid", vcyc_q.size(), 3);
    chk("miss_hold_a", a_word, 8'h11);
    chk("miss_hold_b", b_word, 8'hEE);
    c0 = cyc;
    send(8'h77, 8'h88, 16, 1, -1);
    idle(3);
    chk_frame("relock", 4, c0 + 17, 8'h77, 8'h88);
    chk("relock_err", ecount, e0 + 1);
    send(8'hFF, 8'hFF, 9, 1, -1);
    rst_n = 0;
    #1;
    chk_zero("async_rst");
    idle(2);
    chk_zero("in_rst");
    rst_n = 1;
    e0 = ecount; c0 = cyc;
    send(8'h5A, 8'hC3, 16, 1, -1);
    idle(3);
    chk_frame("post_rst", 5, c0 + 17, 8'h5A, 8'hC3);
    chk("post_rst_err", ecount, e0);
    c0 = cyc;
    send(8'h12, 8'h34, 16, 1, -1);
    send(8'h56, 8'h78, 16, 1, -1);
    send(8'h9A, 8'hBC, 16, 1, -1);
    idle(3);
    chk("b2b_count", vcyc_q.size(), 8);
    if (vcyc_q.size() == 8) begin
      chk("b2b_cyc0", vcyc_q[5], c0 + 17);
      chk("b2b_cyc1", vcyc_q[6], c0 + 33);
      chk("b2b_cyc2", vcyc_q[7], c0 + 49);
      chk("b2b_a0", va_q[5], 8'h12);
      chk("b2b_b0", vb_q[5], 8'h34);
      chk("b2b_a1", va_q[6], 8'h56);
      chk("b2b_b1", vb_q[6], 8'h78);
      chk("b2b_a2", va_q[7], 8'h9A);
      chk("b2b_b2", vb_q[7], 8'hBC);
    end
    chk("b2b_err", ecount, e0);
    chk("valid_skew", skew, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
